// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity and 1 or 2 stop bits, with a registered serial output.
module uart_tx_cfg #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = (STOP_BITS == 2);
   // Out-of-range PARITY values fall back to no parity.
   localparam bit                PAR_EN    = (PARITY == 1) || (PARITY == 2);
   localparam bit                PAR_ODD   = (PARITY == 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   logic [2:0]           r_state;
   logic [2:0]           w_state_d;
   logic [BAUD_W-1:0]    r_baud;
   logic [BAUD_W-1:0]    w_baud_d;
   logic [BIT_W-1:0]     r_bit;
   logic [BIT_W-1:0]     w_bit_d;
   logic                 r_stop;
   logic                 w_stop_d;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_d;
   logic                 r_par;
   logic                 w_par_d;
   logic                 r_tx;
   logic                 w_tx_d;
   logic                 w_baud_end;
   logic                 w_par_calc;

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_par_calc = PAR_ODD ? ~^tx_data : ^tx_data;

   always_comb begin
      w_state_d = r_state;
      w_baud_d  = r_baud + 1'b1;
      w_bit_d   = r_bit;
      w_stop_d  = r_stop;
      w_shift_d = r_shift;
      w_par_d   = r_par;
      w_tx_d    = r_tx;

      case (r_state)
         ST_IDLE: begin
            w_baud_d = '0;
            w_bit_d  = '0;
            w_stop_d = 1'b0;
            w_tx_d   = 1'b1;
            if (tx_valid) begin
               w_shift_d = tx_data;
               w_par_d   = w_par_calc;
               w_state_d = ST_START;
               w_tx_d    = 1'b0;
            end
         end

         ST_START: begin
            if (w_baud_end) begin
               w_baud_d  = '0;
               w_state_d = ST_DATA;
               w_tx_d    = r_shift[0];
            end
         end

         ST_DATA: begin
            if (w_baud_end) begin
               w_baud_d = '0;
               if (r_bit == BIT_LAST) begin
                  w_bit_d = '0;
                  if (PAR_EN) begin
                     w_state_d = ST_PAR;
                     w_tx_d    = r_par;
                  end else begin
                     w_state_d = ST_STOP;
                     w_tx_d    = 1'b1;
                  end
               end else begin
                  // Next bit is pre-loaded so tx switches on the bit boundary edge.
                  w_bit_d   = r_bit + 1'b1;
                  w_shift_d = r_shift >> 1;
                  w_tx_d    = r_shift[1];
               end
            end
         end

         ST_PAR: begin
            if (w_baud_end) begin
               w_baud_d  = '0;
               w_state_d = ST_STOP;
               w_tx_d    = 1'b1;
            end
         end

         ST_STOP: begin
            w_tx_d = 1'b1;
            if (w_baud_end) begin
               w_baud_d = '0;
               if (r_stop == STOP_LAST) begin
                  w_stop_d  = 1'b0;
                  w_state_d = ST_IDLE;
               end else begin
                  w_stop_d = r_stop + 1'b1;
               end
            end
         end

         default: begin
            w_state_d = ST_IDLE;
            w_baud_d  = '0;
            w_bit_d   = '0;
            w_stop_d  = 1'b0;
            w_tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_stop  <= 1'b0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_baud  <= w_baud_d;
         r_bit   <= w_bit_d;
         r_stop  <= w_stop_d;
         r_shift <= w_shift_d;
         r_par   <= w_par_d;
         r_tx    <= w_tx_d;
      end
   end

   assign tx       = r_tx;
   assign tx_ready = (r_state == ST_IDLE);
   assign busy     = ~tx_ready;
   assign done     = (r_state == ST_STOP) && w_baud_end && (r_stop == STOP_LAST);

endmodule
